// File: rtl/npp2noc_tx.sv
// npp2noc_tx: NPP beat to NoC flit transmit adapter with framing check, beat FIFO and credit gating.
// Define NPP_TX_PKT_CNT_EN to add the tx_pkt_cnt output counting transmitted tail flits.
module npp2noc_tx #(
  parameter int DATA_WIDTH = 128,
  parameter int FIFO_DEPTH = 4,
  parameter int CREDIT_NUM = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  npp_valid,
  output logic                  npp_ready,
  input  logic [DATA_WIDTH-1:0] npp_data,
  input  logic                  npp_head,
  input  logic                  npp_tail,
  output logic [DATA_WIDTH:0]   noc_data,
  output logic                  m_is_head,
  output logic                  m_is_tail,
  input  logic                  noc_credit_in,
  output logic                  pkt_err
`ifdef NPP_TX_PKT_CNT_EN
  ,
  output logic [15:0]           tx_pkt_cnt
`endif
);

  localparam int ADDR_W   = $clog2(FIFO_DEPTH);
  localparam int PTR_W    = ADDR_W + 1;
  localparam int CREDIT_W = $clog2(CREDIT_NUM + 1);
  localparam int ENTRY_W  = DATA_WIDTH + 2;

  typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

  state_t              state;
  state_t              state_next;
  logic [ENTRY_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CREDIT_W-1:0] credit;
  logic                accept;
  logic                wr_en;
  logic                rd_en;
  logic                err_next;
  logic [ENTRY_W-1:0]  rd_entry;

  // Extra pointer MSB tells a full FIFO apart from an empty one with equal addresses.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                      (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  assign npp_ready  = ~fifo_full;
  assign accept     = npp_valid & npp_ready;
  assign rd_en      = ~fifo_empty & (credit != '0);
  assign rd_entry   = mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (accept) begin
      case (state)
        IDLE:    if (npp_head && !npp_tail) state_next = IN_PKT;
        IN_PKT:  if (!npp_head && npp_tail) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Misframed beats are still consumed so the producer never stalls on them.
  always_comb begin
    wr_en    = 1'b0;
    err_next = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          wr_en    = npp_head;
          err_next = ~npp_head;
        end
        IN_PKT: begin
          wr_en    = ~npp_head;
          err_next = npp_head;
        end
        default: begin
          wr_en    = 1'b0;
          err_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pkt_err <= 1'b0;
    else        pkt_err <= err_next;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= {npp_head, npp_tail, npp_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit <= CREDIT_W'(CREDIT_NUM);
    end else begin
      case ({rd_en, noc_credit_in})
        2'b10:   credit <= credit - CREDIT_W'(1);
        2'b01:   if (credit != CREDIT_W'(CREDIT_NUM)) credit <= credit + CREDIT_W'(1);
        default: credit <= credit;
      endcase
    end
  end

  // The output register is reloaded every cycle, so each flit is valid for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      noc_data  <= '0;
      m_is_head <= 1'b0;
      m_is_tail <= 1'b0;
    end else if (rd_en) begin
      noc_data  <= {1'b1, rd_entry[DATA_WIDTH-1:0]};
      m_is_head <= rd_entry[DATA_WIDTH+1];
      m_is_tail <= rd_entry[DATA_WIDTH];
    end else begin
      noc_data  <= '0;
      m_is_head <= 1'b0;
      m_is_tail <= 1'b0;
    end
  end

`ifdef NPP_TX_PKT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          tx_pkt_cnt <= '0;
    else if (rd_en && rd_entry[DATA_WIDTH]) tx_pkt_cnt <= tx_pkt_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_npp2noc_tx.sv
// tb_npp2noc_tx: directed plus randomized bench for npp2noc_tx, checked against a queue-based model.
// Compile with NPP_TX_PKT_CNT_EN defined to also check tx_pkt_cnt.
module tb_npp2noc_tx;

  localparam int DW    = 128;
  localparam int DEPTH = 4;
  localparam int CN    = 4;
  localparam int CW    = DW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          npp_valid = 1'b0;
  logic          npp_ready;
  logic [DW-1:0] npp_data = '0;
  logic          npp_head = 1'b0;
  logic          npp_tail = 1'b0;
  logic [DW:0]   noc_data;
  logic          m_is_head;
  logic          m_is_tail;
  logic          noc_credit_in = 1'b0;
  logic          pkt_err;
`ifdef NPP_TX_PKT_CNT_EN
  logic [15:0]   tx_pkt_cnt;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: queue of buffered beats {head, tail, data}, credit count, open-packet flag.
  logic [DW+1:0] model_q[$];
  int            model_credit;
  bit            model_in_pkt;
  logic [15:0]   model_cnt;
  int            flits_seen;
  bit            last_valid;
  bit            last_accept;

  npp2noc_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CREDIT_NUM(CN)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .npp_valid(npp_valid),
    .npp_ready(npp_ready),
    .npp_data(npp_data),
    .npp_head(npp_head),
    .npp_tail(npp_tail),
    .noc_data(noc_data),
    .m_is_head(m_is_head),
    .m_is_tail(m_is_tail),
    .noc_credit_in(noc_credit_in),
    .pkt_err(pkt_err)
`ifdef NPP_TX_PKT_CNT_EN
    , .tx_pkt_cnt(tx_pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rndData();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic checkOutput(input string tag, input logic [DW:0] observed, input logic [DW:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    model_q.delete();
    model_credit = CN;
    model_in_pkt = 1'b0;
    model_cnt    = '0;
    last_valid   = 1'b0;
    last_accept  = 1'b0;
  endtask

  // Drives one cycle of inputs just after an edge, advances the model, then checks after the next edge.
  task automatic applyStimulus(input bit v, input bit h, input bit t, input logic [DW-1:0] d, input bit cin);
    bit            ready_exp;
    bit            accept;
    bit            issue;
    bit            err;
    logic [DW+1:0] ent;
    logic [DW:0]   exp_flit;
    npp_valid     = v;
    npp_head      = h;
    npp_tail      = t;
    npp_data      = d;
    noc_credit_in = cin;
    ready_exp = (model_q.size() < DEPTH);
    accept    = v && ready_exp;
    issue     = (model_q.size() != 0) && (model_credit > 0);
    ent       = '0;
    if (issue) ent = model_q.pop_front();
    if (issue && !cin)                        model_credit--;
    else if (!issue && cin && model_credit < CN) model_credit++;
    err = 1'b0;
    if (accept) begin
      if (model_in_pkt == h) err = 1'b1;
      else begin
        model_q.push_back({h, t, d});
        model_in_pkt = !t;
      end
    end
    if (issue && ent[DW]) model_cnt++;
    exp_flit    = issue ? {1'b1, ent[DW-1:0]} : '0;
    last_valid  = v;
    last_accept = accept;
    @(posedge clk);
    #1;
    checkOutput("noc_data", noc_data, exp_flit);
    checkOutput("m_is_head", CW'(m_is_head), CW'(issue && ent[DW+1]));
    checkOutput("m_is_tail", CW'(m_is_tail), CW'(issue && ent[DW]));
    checkOutput("pkt_err", CW'(pkt_err), CW'(err));
    checkOutput("npp_ready", CW'(npp_ready), CW'(model_q.size() < DEPTH));
    checkOutput("credit", CW'(dut.credit), CW'(model_credit));
`ifdef NPP_TX_PKT_CNT_EN
    checkOutput("tx_pkt_cnt", CW'(tx_pkt_cnt), CW'(model_cnt));
`endif
    if (noc_data[DW]) flits_seen++;
  endtask

  task automatic idleCycles(input int n, input bit cin);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, cin);
  endtask

  initial begin
    bit            rv;
    bit            rh;
    bit            rt;
    bit            rc;
    logic [DW-1:0] rd;
    modelReset();
    flits_seen = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_noc_data", noc_data, '0);
    checkOutput("reset_pkt_err", CW'(pkt_err), '0);
    checkOutput("reset_credit", CW'(dut.credit), CW'(CN));
    rst_n = 1'b1;
    $display("[TB] reset released, idle phase");
    idleCycles(10, 1'b0);

    $display("[TB] three-beat packet");
    applyStimulus(1'b1, 1'b1, 1'b0, DW'(32'hA), 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, DW'(32'hB), 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, DW'(32'hC), 1'b0);
    idleCycles(2, 1'b0);
    checkOutput("credit_after_pkt", CW'(dut.credit), CW'(1));
    idleCycles(3, 1'b1);

    $display("[TB] six single-beat packets without credit return");
    flits_seen = 0;
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b1, rndData(), 1'b0);
    idleCycles(3, 1'b0);
    checkOutput("flits_no_credit", CW'(flits_seen), CW'(4));
    checkOutput("ready_two_queued", CW'(npp_ready), CW'(1));
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    idleCycles(2, 1'b0);
    checkOutput("flits_one_credit", CW'(flits_seen), CW'(5));
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, rndData(), 1'b0);
    checkOutput("ready_full", CW'(npp_ready), CW'(0));
    rd = rndData();
    applyStimulus(1'b1, 1'b1, 1'b1, rd, 1'b0);
    for (int i = 0; i < 20 && !last_accept; i++) applyStimulus(1'b1, 1'b1, 1'b1, rd, 1'b1);
    idleCycles(10, 1'b1);
    checkOutput("credit_saturated", CW'(dut.credit), CW'(CN));

    $display("[TB] framing errors");
    applyStimulus(1'b1, 1'b0, 1'b0, rndData(), 1'b0);
    idleCycles(2, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, rndData(), 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, rndData(), 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, rndData(), 1'b0);
    idleCycles(3, 1'b0);
    idleCycles(4, 1'b1);

    $display("[TB] simultaneous issue and credit return");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b1, rndData(), 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("credit_issue_return", CW'(dut.credit), CW'(1));
    idleCycles(4, 1'b1);
    checkOutput("credit_extra_return", CW'(dut.credit), CW'(CN));

    $display("[TB] randomized traffic");
    rv = 1'b0; rh = 1'b0; rt = 1'b0; rd = '0;
    for (int i = 0; i < 300; i++) begin
      if (!(last_valid && !last_accept)) begin
        rv = ($urandom_range(0, 3) != 0);
        rh = 1'($urandom_range(0, 1));
        rt = 1'($urandom_range(0, 1));
        rd = rndData();
      end
      rc = ($urandom_range(0, 2) == 0);
      applyStimulus(rv, rh, rt, rd, rc);
    end
    for (int i = 0; i < 20 && last_valid && !last_accept; i++) applyStimulus(rv, rh, rt, rd, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, rndData(), 1'b1);
    idleCycles(12, 1'b1);

    $display("[TB] reset with an open packet buffered");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b1, rndData(), 1'b0);
    idleCycles(2, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, rndData(), 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, rndData(), 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, rndData(), 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("flit_before_reset", CW'(noc_data[DW]), CW'(1));
    rst_n = 1'b0;
    #1;
    checkOutput("reset_flit_valid", CW'(noc_data[DW]), '0);
    checkOutput("reset_credit_mid", CW'(dut.credit), CW'(CN));
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
`ifdef NPP_TX_PKT_CNT_EN
    checkOutput("cnt_after_reset", CW'(tx_pkt_cnt), '0);
`endif
    flits_seen = 0;
    idleCycles(5, 1'b0);
    checkOutput("no_stale_flits", CW'(flits_seen), '0);
    applyStimulus(1'b1, 1'b1, 1'b0, rndData(), 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, rndData(), 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, rndData(), 1'b0);
    idleCycles(4, 1'b0);
    checkOutput("flits_after_reset", CW'(flits_seen), CW'(3));
`ifdef NPP_TX_PKT_CNT_EN
    checkOutput("cnt_two_tails", CW'(tx_pkt_cnt), CW'(2));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
